// File: rtl/sam_con_seq.sv
// Run sequencer for the SAM_Con convolution engine: holds the configuration, streams
// samples and kernel coefficients into the engine, and collects one result per output window.
module sam_con_seq #(
    parameter int MAX_KERNEL_SIZE = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Cfg_We,
    input  logic [1:0]  Cfg_Addr,
    input  logic [31:0] Cfg_Wdata,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [31:0] In_Data,
    input  logic        In_Last,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_Data,
    output logic        Sam_Rst,
    output logic        Sam_En,
    output logic [7:0]  Sam_Stride,
    output logic [7:0]  Sam_Kernel_Size,
    output logic [31:0] Sam_Data_In,
    output logic [1:0]  Sam_Kernel_In,
    output logic        Sam_Last_In,
    input  logic [31:0] Sam_Data_Out,
    input  logic        Sam_Last_Out
);

    typedef enum logic [1:0] {ST_IDLE, ST_CLR, ST_RUN, ST_FLUSH} state_e;
    typedef enum logic [1:0] {PH_LOAD, PH_COMP, PH_WAIT, PH_WRAP} phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  stride_q, stride_d;
    logic [7:0]  ksize_q, ksize_d;
    logic [31:0] kword_q, kword_d;
    logic [31:0] out_data_q, out_data_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        out_valid_q, out_valid_d;
    logic        pend_q, pend_d;
    logic        sam_rst_q, sam_rst_d;

    logic        in_ready;
    logic        sam_en;
    logic        bad_cfg;

    // Only one result may be in flight: a new sample is taken only once the last one is gone.
    assign in_ready = (state_q == ST_RUN) && !out_valid_q && !pend_q;
    assign sam_en   = In_Valid && in_ready;
    assign bad_cfg  = (ksize_q == 8'd0) || (int'(ksize_q) > MAX_KERNEL_SIZE) || (stride_q == 8'd0);

    always_comb begin
        // NOTE: every signal written here gets its default first so no latch can be inferred.
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        stride_d    = stride_q;
        ksize_d     = ksize_q;
        kword_d     = kword_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        pend_d      = sam_en && (phase_q == PH_COMP);

        if (Cfg_We && (state_q == ST_IDLE)) begin
            case (Cfg_Addr)
                2'd0:    stride_d = Cfg_Wdata[7:0];
                2'd1:    ksize_d  = Cfg_Wdata[7:0];
                2'd2:    kword_d  = Cfg_Wdata;
                default: ;
            endcase
        end

        // Mirror of the engine's window phase; only accepted samples move it.
        case (phase_q)
            PH_LOAD: begin
                if (sam_en) begin
                    cnt_d = cnt_q + 8'd1;
                    if (In_Last)                         phase_d = PH_WRAP;
                    else if (cnt_q == ksize_q - 8'd1)    phase_d = PH_COMP;
                end
            end
            PH_COMP: begin
                cnt_d = 8'd0;
                if (sam_en) begin
                    if (In_Last)                         phase_d = PH_WRAP;
                    else if (stride_q != 8'd1)           phase_d = PH_WAIT;
                end
            end
            PH_WAIT: begin
                if (sam_en) begin
                    cnt_d = cnt_q + 8'd1;
                    if (In_Last)                         phase_d = PH_WRAP;
                    else if (cnt_q == stride_q - 8'd1)   phase_d = PH_COMP;
                end
            end
            PH_WRAP: ;
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    err_d = bad_cfg;
                    if (!bad_cfg) state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = ST_RUN;
                phase_d = PH_LOAD;
                cnt_d   = 8'd0;
            end
            ST_RUN: begin
                if (sam_en && In_Last) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!out_valid_q && !pend_q && (Sam_Last_Out || (phase_q == PH_WRAP))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The engine result is valid the cycle after a window sample is taken.
        if (pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = Sam_Data_Out;
        end else if (out_valid_q && Out_Ready) begin
            out_valid_d = 1'b0;
        end

        sam_rst_d = (state_d == ST_CLR);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            state_q     <= ST_IDLE;
            phase_q     <= PH_LOAD;
            cnt_q       <= 8'd0;
            stride_q    <= 8'd1;
            ksize_q     <= 8'd1;
            kword_q     <= 32'd0;
            out_data_q  <= 32'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            sam_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            stride_q    <= stride_d;
            ksize_q     <= ksize_d;
            kword_q     <= kword_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            pend_q      <= pend_d;
            sam_rst_q   <= sam_rst_d;
        end
    end

    assign Busy            = (state_q != ST_IDLE);
    assign Done            = done_q;
    assign Err             = err_q;
    assign In_Ready        = in_ready;
    assign Out_Valid       = out_valid_q;
    assign Out_Data        = out_data_q;
    assign Sam_Rst         = sam_rst_q;
    assign Sam_En          = sam_en;
    assign Sam_Stride      = stride_q;
    assign Sam_Kernel_Size = ksize_q;
    assign Sam_Data_In     = In_Data;
    assign Sam_Last_In     = In_Last && (state_q == ST_RUN);
    assign Sam_Kernel_In   = ((state_q == ST_RUN) && (phase_q == PH_LOAD)) ?
                             kword_q[{cnt_q[3:0], 1'b0} +: 2] : 2'b00;

endmodule

// File: tb/tb_sam_con_seq.sv
// Scoreboard bench for sam_con_seq with a behavioural SAM_Con engine attached.
module tb_sam_con_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        start, busy, done, err;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        sam_rst, sam_en, sam_last_in;
    logic [7:0]  sam_stride, sam_kernel_size;
    logic [31:0] sam_data_in;
    logic [1:0]  sam_kernel_in;
    logic [31:0] eng_dout;
    logic        eng_last;

    sam_con_seq #(.MAX_KERNEL_SIZE(16)) dut (
        .Clk(clk), .Rst(rst),
        .Cfg_We(cfg_we), .Cfg_Addr(cfg_addr), .Cfg_Wdata(cfg_wdata),
        .Start(start), .Busy(busy), .Done(done), .Err(err),
        .In_Valid(in_valid), .In_Ready(in_ready), .In_Data(in_data), .In_Last(in_last),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Data(out_data),
        .Sam_Rst(sam_rst), .Sam_En(sam_en), .Sam_Stride(sam_stride),
        .Sam_Kernel_Size(sam_kernel_size), .Sam_Data_In(sam_data_in),
        .Sam_Kernel_In(sam_kernel_in), .Sam_Last_In(sam_last_in),
        .Sam_Data_Out(eng_dout), .Sam_Last_Out(eng_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] stim_q[$];
    bit abort = 0;
    bit force_hold = 0;
    bit rdy_rand = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int coef_val(input logic [1:0] c);
        return c[1] ? int'(c) - 4 : int'(c);
    endfunction

    // Engine model: newest sample at eng_hist[0]; coefficient i multiplies the i-th oldest.
    logic [31:0] eng_hist[16];
    logic [1:0]  eng_coef[16];
    int          eng_cnt;

    function automatic logic [31:0] eng_dot(input int k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < k; i++) acc += 32'(coef_val(eng_coef[i])) * eng_hist[k-1-i];
        return acc;
    endfunction

    always @(posedge clk) begin
        if (sam_rst) begin
            eng_cnt  <= 0;
            eng_dout <= '0;
            eng_last <= 1'b0;
        end else begin
            eng_last <= sam_en && sam_last_in;
            if (sam_en) begin
                eng_dout <= (eng_cnt >= int'(sam_kernel_size)) ? eng_dot(int'(sam_kernel_size)) : '0;
                if (eng_cnt < int'(sam_kernel_size) && eng_cnt < 16) eng_coef[eng_cnt] <= sam_kernel_in;
                eng_hist[0] <= sam_data_in;
                for (int i = 1; i < 16; i++) eng_hist[i] <= eng_hist[i-1];
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // Reference: the first result is taken on sample K, later ones every 1 (stride 1)
    // or stride+1 samples; each is the kernel applied to the K samples preceding it.
    function automatic void push_expected(input int k, input logic [31:0] kword, input int stride);
        int step;
        logic [31:0] acc;
        step = (stride == 1) ? 1 : stride + 1;
        for (int p = k; p < stim_q.size(); p += step) begin
            acc = '0;
            for (int i = 0; i < k; i++) acc += 32'(coef_val(kword[2*i +: 2])) * stim_q[p-k+i];
            exp_q.push_back(acc);
        end
    endfunction

    function automatic void fill_seq(input int n);
        stim_q.delete();
        for (int i = 1; i <= n; i++) stim_q.push_back(32'(i));
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: pops the scoreboard on every result handshake and checks hold-while-stalled.
    bit          prev_stall;
    logic [31:0] prev_data;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                check("result_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("result_data", out_data, exp_q.pop_front());
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic check_reset(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_err"}, err, 0);
        check({p, "_in_ready"}, in_ready, 0);
        check({p, "_out_valid"}, out_valid, 0);
        check({p, "_out_data"}, out_data, 0);
        check({p, "_sam_en"}, sam_en, 0);
        check({p, "_sam_last_in"}, sam_last_in, 0);
        check({p, "_sam_rst"}, sam_rst, 1);
        check({p, "_stride"}, sam_stride, 1);
        check({p, "_ksize"}, sam_kernel_size, 1);
        check({p, "_kernel_in"}, sam_kernel_in, 0);
    endtask

    task automatic feed(input int max_gap);
        int t;
        bit stop;
        stop = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (abort || stop) break;
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = stim_q[i];
            in_last  = (i == stim_q.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (abort || in_ready) break;
                t++;
                if (t > 2000) begin
                    check("in_ready_timeout", in_ready, 1);
                    stop = 1;
                    break;
                end
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
    endtask

    task automatic hold_chk(input logic [31:0] first);
        bit got;
        got = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (out_valid) begin got = 1; break; end
        end
        check("hold_first_valid", out_valid, 1);
        if (got) begin
            for (int c = 0; c < 5; c++) begin
                if (c > 0) @(negedge clk);
                check("hold_in_ready", in_ready, 0);
                check("hold_out_data", out_data, first);
            end
        end
        force_hold = 0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_case(input int k, input logic [31:0] kword, input int stride,
                            input int max_gap, input bit rand_rdy, input bit hold, input bit poke);
        logic [31:0] first;
        bit seen;
        cfg_write(2'd0, 32'(stride));
        cfg_write(2'd1, 32'(k));
        cfg_write(2'd2, kword);
        push_expected(k, kword, stride);
        first = (exp_q.size() > 0) ? exp_q[0] : '0;
        rdy_rand   = rand_rdy;
        force_hold = hold;
        start_pulse();
        @(negedge clk);
        check("clr_busy", busy, 1);
        check("clr_sam_rst", sam_rst, 1);
        check("clr_sam_en", sam_en, 0);
        check("clr_err", err, 0);
        @(posedge clk); #1;
        if (poke) begin
            cfg_write(2'd0, 32'h55);
            cfg_write(2'd1, 32'd9);
            cfg_write(2'd2, 32'd0);
            @(negedge clk);
            check("busy_cfg_stride", sam_stride, 32'(stride));
            check("busy_cfg_ksize", sam_kernel_size, 32'(k));
            @(posedge clk); #1;
        end
        fork
            feed(max_gap);
            wait_done(seen);
            begin
                if (hold) hold_chk(first);
            end
        join
        check("done_seen", seen, 1);
        check("results_drained", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        @(posedge clk); #1;
        rdy_rand   = 0;
        force_hold = 0;
    endtask

    task automatic bad_start(input string name);
        start_pulse();
        @(negedge clk);
        check({name, "_err"}, err, 1);
        check({name, "_busy"}, busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_busy_later"}, busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int k, n, s;
        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        fill_seq(6);  run_case(3, 32'h15, 1, 0, 0, 0, 0);     // 6, 9, 12
        fill_seq(8);  run_case(3, 32'h15, 2, 0, 0, 0, 0);     // 6, 15
        stim_q.delete();
        stim_q.push_back(32'd10); stim_q.push_back(32'd3);
        stim_q.push_back(32'd7);  stim_q.push_back(32'd1);
        run_case(3, 32'h0D, 1, 0, 0, 0, 0);                    // 7
        fill_seq(6);  run_case(3, 32'h15, 1, 0, 0, 1, 0);     // back-pressure on first result

        cfg_write(2'd1, 32'd0);  bad_start("ksize0");
        cfg_write(2'd1, 32'd17); bad_start("ksize17");
        cfg_write(2'd1, 32'd3);  cfg_write(2'd0, 32'd0); bad_start("stride0");
        fill_seq(6);  run_case(3, 32'h15, 1, 1, 0, 0, 1);     // also clears Err

        fill_seq(2);  run_case(4, 32'h55, 1, 0, 0, 0, 0);     // last during load
        fill_seq(18); run_case(16, 32'h5555_5555, 1, 0, 1, 0, 0);

        for (int r = 0; r < 16; r++) begin
            k = $urandom_range(1, 5);
            n = $urandom_range(1, 14);
            s = $urandom_range(1, 3);
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back($urandom());
            run_case(k, $urandom(), s, 2, 1, 0, 0);
        end

        // Reset while a result is held mid-stream.
        fill_seq(6);
        cfg_write(2'd0, 32'd1); cfg_write(2'd1, 32'd3); cfg_write(2'd2, 32'h15);
        force_hold = 1;
        start_pulse();
        @(posedge clk); #1;
        fork
            feed(0);
            begin
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                check("midrst_held", out_valid, 1);
                #2 rst = 1'b0;
                #1 check_reset("midrst");
                abort = 1;
            end
        join
        @(posedge clk); #1;
        check("midrst_sam_rst_hold", sam_rst, 1);
        check("midrst_out_valid_hold", out_valid, 0);
        @(negedge clk); #2 rst = 1'b1;
        abort = 0; force_hold = 0;
        @(posedge clk); #1;
        fill_seq(6);  run_case(3, 32'h15, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
